decoder_scan_sequencer: RTL and testbench
=========================================

// Module: decoder_scan_sequencer
// PURPOSE
//   Drives the select inputs (A,B,C) and enable (en) of the 3-to-8 active-low decoder.
//   It scans the enabled rows in a repeating frame: blank gap, then a timed dwell per row.
//   Select lines change only while en=0, so the decoder outputs never glitch between rows.
//   Sits directly upstream of the decoder in display/keypad row-scan paths.
// PARAMETERS
//   DWELL_W    8  width of the dwell-length input and the dwell counter
//   BLANK_CYC  2  en-low guard cycles before each row; 0 = no blank state
// PORTS
//   clk         input   1        rising-edge clock
//   rst_n       input   1        asynchronous active-low reset
//   start       input   1        level; begins scanning when sampled in IDLE
//   stop        input   1        1-cycle request; scanning halts at the end of the current frame
//   dwell       input   DWELL_W  en-high cycles per row; 0 is treated as 1
//   row_mask    input   8        bit i=1 -> row i is scanned
//   A,B,C       output  1 each   decoder select; {A,B,C} = row index, A = MSB
//   en          output  1        decoder enable
//   busy        output  1        1 whenever state != IDLE
//   frame_done  output  1        1-cycle pulse when the last enabled row of a frame finishes
// BEHAVIOUR
//   - All outputs are registered. On rst_n=0 (any time, asynchronous):
//     state=IDLE, {A,B,C}=0, en=0, busy=0, frame_done=0, stop_pend=0, counters=0.
//   - States: IDLE, BLANK, DWELL.
//   - IDLE:
//     - start=1, stop=0, row_mask!=0: latch row_mask into mask_q.
//       Load {A,B,C} with the lowest set index. Go to BLANK, or to DWELL if BLANK_CYC=0.
//     - start=1, stop=1 in the same cycle: stop wins; remain in IDLE.
//     - row_mask=0: start is ignored.
//   - BLANK: en=0 for exactly BLANK_CYC cycles, then DWELL.
//   - DWELL:
//     - On entry, sample dwell into the counter.
//     - en=1 for max(dwell,1) cycles, then the row ends.
//   - Row end: the next row is the next set bit of mask_q above the current index.
//     - If one exists, update {A,B,C} and go to BLANK (or DWELL if BLANK_CYC=0).
//       en drops for at least one cycle even when BLANK_CYC=0.
//     - If none exists (wrap), the frame is done:
//       - Pulse frame_done in the same cycle en falls.
//       - If stop_pend=1, or the newly sampled row_mask is 0: go to IDLE, {A,B,C}=0, clear stop_pend.
//       - Otherwise: re-latch mask_q from row_mask, select its lowest set row, continue.
//   - stop sets the sticky stop_pend in any non-IDLE state.
//   - row_mask changes mid-frame have no effect until the next frame boundary.
//   - Invariant: {A,B,C} never changes in a cycle where en=1, or in the cycle en rises.
//   - Single-row mask, e.g. 8'h10: every row end is a frame end.
//     frame_done pulses once per row; {A,B,C}=3'b100 throughout.
//   - en rises on the clock edge after BLANK completes.
//     Latency from start to first en=1 is BLANK_CYC+1 cycles, or 1 cycle if BLANK_CYC=0.
//   - Reset asserted mid-DWELL: en drops immediately (asynchronous). After release, the block stays in IDLE.
// TESTING
//   1. row_mask=8'hFF, dwell=3, BLANK_CYC=2, start pulse:
//      {A,B,C} steps 0..7; each row gives 2 cycles en=0 then 3 cycles en=1.
//      frame_done pulses once every 40 cycles; then rows 0..7 repeat.
//   2. row_mask=8'b1010_0100, dwell=1:
//      rows scanned 2,5,7,2,...; frame_done after row 7; select stable whenever en=1.
//   3. stop pulsed during row 3 of an 8-row frame:
//      rows 4..7 still complete; frame_done pulses; busy=0 and {A,B,C}=0 next cycle.
//   4. dwell=0 -> en high 1 cycle per row.
//      row_mask changed from 8'hFF to 8'h01 mid-frame: current frame finishes all 8 rows,
//      then only row 0 is scanned.
//   5. start with row_mask=0 -> busy stays 0. start+stop in the same cycle -> stays IDLE.
//   6. rst_n low for 1 cycle mid-DWELL:
//      en, busy and frame_done drop at once; {A,B,C}=0; no activity until the next start.

Source files
------------

// File: rtl/decoder_scan_sequencer.sv
// Row-scan sequencer for a 3-to-8 active-low decoder: blank gap, then a timed dwell per enabled row.
// Select lines only move while en is low, so decoder outputs never glitch between rows.
module decoder_scan_sequencer #(
   parameter int unsigned DWELL_W   = 8,
   parameter int unsigned BLANK_CYC = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               stop,
   input  logic [DWELL_W-1:0] dwell,
   input  logic [7:0]         row_mask,
   output logic               A,
   output logic               B,
   output logic               C,
   output logic               en,
   output logic               busy,
   output logic               frame_done
);

   // Row-to-row gaps need at least one en-low cycle even without a blank guard.
   localparam int unsigned BLEN = (BLANK_CYC == 0) ? 1 : BLANK_CYC;
   localparam int unsigned BW   = (BLEN > 1) ? $clog2(BLEN) : 1;
   localparam logic [BW-1:0] BLANK_LOAD = BW'(BLEN - 1);

   typedef enum logic [1:0] {StIdle, StBlank, StDwell} state_t;

   state_t             state_q, state_d;
   logic [2:0]         sel_q, sel_d;
   logic [7:0]         mask_q, mask_d;
   logic               stop_pend_q, stop_pend_d;
   logic [DWELL_W-1:0] dcnt_q, dcnt_d;
   logic [BW-1:0]      bcnt_q, bcnt_d;
   logic               en_q, en_d;
   logic               busy_q, busy_d;
   logic               fd_q, fd_d;

   logic [2:0]         first_row;
   logic [2:0]         next_row;
   logic               next_valid;
   logic [DWELL_W-1:0] dwell_load;
   logic               stop_now;

   always_comb begin
      first_row = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (row_mask[i]) first_row = 3'(i);
      end
   end

   always_comb begin
      next_row   = 3'd0;
      next_valid = 1'b0;
      for (int i = 7; i >= 0; i--) begin
         if (mask_q[i] && (i > int'(sel_q))) begin
            next_row   = 3'(i);
            next_valid = 1'b1;
         end
      end
   end

   assign dwell_load = (dwell == '0) ? '0 : dwell - DWELL_W'(1);
   assign stop_now   = stop_pend_q | stop;

   always_comb begin
      state_d     = state_q;
      sel_d       = sel_q;
      mask_d      = mask_q;
      stop_pend_d = stop_pend_q;
      dcnt_d      = dcnt_q;
      bcnt_d      = bcnt_q;
      fd_d        = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (start && !stop && (row_mask != 8'h00)) begin
               mask_d      = row_mask;
               sel_d       = first_row;
               stop_pend_d = 1'b0;
               if (BLANK_CYC == 0) begin
                  state_d = StDwell;
                  dcnt_d  = dwell_load;
               end else begin
                  state_d = StBlank;
                  bcnt_d  = BLANK_LOAD;
               end
            end
         end
         StBlank: begin
            stop_pend_d = stop_now;
            if (bcnt_q == '0) begin
               state_d = StDwell;
               dcnt_d  = dwell_load;
            end else begin
               bcnt_d = bcnt_q - BW'(1);
            end
         end
         StDwell: begin
            stop_pend_d = stop_now;
            if (dcnt_q != '0) begin
               dcnt_d = dcnt_q - DWELL_W'(1);
            end else if (next_valid) begin
               sel_d   = next_row;
               state_d = StBlank;
               bcnt_d  = BLANK_LOAD;
            end else begin
               // Frame boundary: the only point where row_mask and stop are acted on.
               fd_d = 1'b1;
               if (stop_now || (row_mask == 8'h00)) begin
                  state_d     = StIdle;
                  sel_d       = 3'd0;
                  stop_pend_d = 1'b0;
               end else begin
                  mask_d  = row_mask;
                  sel_d   = first_row;
                  state_d = StBlank;
                  bcnt_d  = BLANK_LOAD;
               end
            end
         end
         default: begin
            state_d = StIdle;
            sel_d   = 3'd0;
         end
      endcase

      en_d   = (state_d == StDwell);
      busy_d = (state_d != StIdle);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         sel_q       <= 3'd0;
         mask_q      <= 8'h00;
         stop_pend_q <= 1'b0;
         dcnt_q      <= '0;
         bcnt_q      <= '0;
         en_q        <= 1'b0;
         busy_q      <= 1'b0;
         fd_q        <= 1'b0;
      end else begin
         state_q     <= state_d;
         sel_q       <= sel_d;
         mask_q      <= mask_d;
         stop_pend_q <= stop_pend_d;
         dcnt_q      <= dcnt_d;
         bcnt_q      <= bcnt_d;
         en_q        <= en_d;
         busy_q      <= busy_d;
         fd_q        <= fd_d;
      end
   end

   assign A          = sel_q[2];
   assign B          = sel_q[1];
   assign C          = sel_q[0];
   assign en         = en_q;
   assign busy       = busy_q;
   assign frame_done = fd_q;

endmodule

// File: tb/tb_decoder_scan_sequencer.sv
// Bench for decoder_scan_sequencer: row-timeline reference model checked every cycle,
// plus directed scenarios with hand-computed expectations and a randomized soak.
module tb_decoder_scan_sequencer;

   localparam int unsigned DWELL_W   = 8;
   localparam int unsigned BLANK_CYC = 2;

   logic               clk;
   logic               rst_n;
   logic               start;
   logic               stop;
   logic [DWELL_W-1:0] dwell;
   logic [7:0]         row_mask;
   logic               A, B, C, en, busy, frame_done;

   int errors = 0;
   int checks = 0;

   decoder_scan_sequencer #(
      .DWELL_W   (DWELL_W),
      .BLANK_CYC (BLANK_CYC)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .stop       (stop),
      .dwell      (dwell),
      .row_mask   (row_mask),
      .A          (A),
      .B          (B),
      .C          (C),
      .en         (en),
      .busy       (busy),
      .frame_done (frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int low8(input logic [7:0] m);
      int r = 0;
      for (int i = 7; i >= 0; i--) if (m[i]) r = i;
      return r;
   endfunction

   function automatic int next_above(input logic [7:0] m, input int cur);
      int r = -1;
      for (int i = 7; i > cur; i--) if (m[i]) r = i;
      return r;
   endfunction

   function automatic int dw1(input logic [DWELL_W-1:0] d);
      return (d == 0) ? 1 : int'(d);
   endfunction

   // Model: a row is a timeline of g en-low cycles followed by len en-high cycles (t counts
   // cycles into the row). The first row after start has g=BLANK_CYC, later rows max(BLANK_CYC,1).
   localparam int GAP_LATER = (BLANK_CYC == 0) ? 1 : BLANK_CYC;
   int         m_run, m_row, m_t, m_g, m_len, m_stp, m_nx;
   logic [7:0] m_mask;
   logic       e_fd;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_run = 0; m_row = 0; m_t = 0; m_g = 0; m_len = 1; m_stp = 0; m_mask = 0; e_fd = 0;
      end else begin
         e_fd = 0;
         if (m_run == 0) begin
            if (start && !stop && row_mask != 0) begin
               m_run = 1; m_mask = row_mask; m_row = low8(row_mask); m_t = 0;
               m_g = BLANK_CYC; m_stp = 0;
               if (m_g == 0) m_len = dw1(dwell);
            end
         end else begin
            if (stop) m_stp = 1;
            if (m_t >= m_g && m_t == m_g + m_len - 1) begin
               m_nx = next_above(m_mask, m_row);
               if (m_nx >= 0) begin
                  m_row = m_nx; m_t = 0; m_g = GAP_LATER;
               end else begin
                  e_fd = 1;
                  if (m_stp != 0 || row_mask == 0) begin
                     m_run = 0; m_row = 0; m_stp = 0; m_t = 0;
                  end else begin
                     m_mask = row_mask; m_row = low8(row_mask); m_t = 0; m_g = GAP_LATER;
                  end
               end
            end else begin
               m_t++;
               if (m_t == m_g) m_len = dw1(dwell);
            end
         end
      end
   end

   always @(negedge clk) begin
      chk("model_en", int'(en), int'(m_run != 0 && m_t >= m_g));
      chk("model_busy", int'(busy), m_run);
      chk("model_frame_done", int'(frame_done), int'(e_fd));
      chk("model_sel", int'({A, B, C}), m_row);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle(input int budget);
      int k = 0;
      while (busy && k < budget) begin
         tick();
         k++;
      end
      chk("reach_idle", int'(busy), 0);
   endtask

   task automatic go_idle();
      stop = 1'b1;
      start = 1'b0;
      tick();
      stop = 1'b0;
      wait_idle(600);
   endtask

   int k, n, en_cnt, bad;
   int rows[$];
   logic prev_en;

   initial begin
      rst_n = 1'b0; start = 1'b0; stop = 1'b0; dwell = '0; row_mask = 8'h00;
      tick();
      chk("rst_en", int'(en), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_frame_done", int'(frame_done), 0);
      chk("rst_sel", int'({A, B, C}), 0);
      #2 rst_n = 1'b1;
      tick();

      // Full mask, dwell 3: latency BLANK_CYC+1, 40-cycle frames, 24 en-high cycles each.
      row_mask = 8'hFF; dwell = 8'd3; start = 1'b1; k = 0;
      do begin
         tick(); k++; start = 1'b0;
      end while (!en && k < 20);
      chk("t1_first_en_latency", k, 3);
      chk("t1_first_sel", int'({A, B, C}), 0);
      k = 0;
      while (!frame_done && k < 100) begin tick(); k++; end
      n = 0; en_cnt = 0;
      do begin
         tick(); n++;
         if (en) en_cnt++;
      end while (!frame_done && n < 100);
      chk("t1_frame_period", n, 40);
      chk("t1_en_cycles_per_frame", en_cnt, 24);
      go_idle();

      // Sparse mask: rows 2,5,7,2 in order of en rising.
      row_mask = 8'b1010_0100; dwell = 8'd1; start = 1'b1; prev_en = 1'b0; rows = {}; k = 0;
      while (rows.size() < 4 && k < 200) begin
         tick(); k++; start = 1'b0;
         if (en && !prev_en) rows.push_back(int'({A, B, C}));
         prev_en = en;
      end
      chk("t2_rows_seen", rows.size(), 4);
      if (rows.size() == 4) begin
         chk("t2_row0", rows[0], 2);
         chk("t2_row1", rows[1], 5);
         chk("t2_row2", rows[2], 7);
         chk("t2_row3", rows[3], 2);
      end
      go_idle();

      // Stop during row 3: rows 4..7 still run, then idle with select cleared.
      row_mask = 8'hFF; dwell = 8'd2; start = 1'b1; k = 0;
      do begin
         tick(); k++; start = 1'b0;
      end while (!(en && {A, B, C} == 3'd3) && k < 200);
      stop = 1'b1; tick(); stop = 1'b0;
      prev_en = 1'b1; en_cnt = 0; n = 0; bad = 0;
      while (busy && n < 200) begin
         if (frame_done) bad++;
         if (en && !prev_en) en_cnt++;
         prev_en = en;
         tick(); n++;
      end
      chk("t3_rows_after_stop", en_cnt, 4);
      chk("t3_frame_done_at_idle", int'(frame_done), 1);
      chk("t3_idle_sel", int'({A, B, C}), 0);
      chk("t3_no_early_frame_done", bad, 0);
      tick();

      // dwell=0 behaves as 1; a mask change mid-frame waits for the frame boundary.
      row_mask = 8'hFF; dwell = 8'd0; start = 1'b1; k = 0;
      do begin
         tick(); k++; start = 1'b0;
      end while (!(en && {A, B, C} == 3'd2) && k < 200);
      n = 0;
      while (en && n < 10) begin tick(); n++; end
      chk("t4_dwell0_width", n, 1);
      row_mask = 8'h01; prev_en = 1'b0; en_cnt = 0; k = 0;
      while (!frame_done && k < 200) begin
         if (en && !prev_en) en_cnt++;
         prev_en = en;
         tick(); k++;
      end
      chk("t4_rows_after_change", en_cnt, 5);
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if ({A, B, C} != 3'd0) bad++;
      end
      chk("t4_only_row0", bad, 0);
      go_idle();

      // start ignored with empty mask; start+stop together stays idle.
      row_mask = 8'h00; start = 1'b1;
      tick(); tick();
      chk("t5_empty_mask_busy", int'(busy), 0);
      row_mask = 8'hFF; stop = 1'b1;
      tick();
      chk("t5_start_stop_busy", int'(busy), 0);
      start = 1'b0; stop = 1'b0;
      tick();

      // Single-row mask: select pinned at 4, frame_done every row (3 cycles).
      row_mask = 8'h10; dwell = 8'd1; start = 1'b1;
      tick(); start = 1'b0;
      chk("t6_sel_row4", int'({A, B, C}), 4);
      k = 0;
      while (!frame_done && k < 20) begin tick(); k++; end
      n = 0;
      do begin tick(); n++; end while (!frame_done && n < 20);
      chk("t6_frame_period", n, 3);
      go_idle();

      // Async reset mid-dwell.
      row_mask = 8'hFF; dwell = 8'd5; start = 1'b1; k = 0;
      do begin
         tick(); k++; start = 1'b0;
      end while (!en && k < 20);
      #2 rst_n = 1'b0;
      #1;
      chk("t7_rst_en", int'(en), 0);
      chk("t7_rst_busy", int'(busy), 0);
      chk("t7_rst_sel", int'({A, B, C}), 0);
      @(posedge clk); #3 rst_n = 1'b1;
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (busy || en) bad++;
      end
      chk("t7_quiet_after_reset", bad, 0);

      // Randomized soak against the model.
      for (int i = 0; i < 4000; i++) begin
         start = ($urandom_range(0, 3) == 0);
         stop  = ($urandom_range(0, 39) == 0);
         dwell = DWELL_W'($urandom_range(0, 4));
         if ($urandom_range(0, 49) == 0)
            row_mask = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
         if ($urandom_range(0, 799) == 0) begin
            #2 rst_n = 1'b0;
            @(posedge clk); #3 rst_n = 1'b1;
         end
         tick();
      end

      start = 1'b0; stop = 1'b0;
      tick();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
